// File: rtl/bin_to_bcd_dabble_pkg.sv
// Shared definitions for the double-dabble binary-to-BCD converter:
// FSM state encoding, BCD digit constants and the per-digit adjust rule.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         BCD_DIGIT_W       = 4;
    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

    // Digits of 5..9 become 8..12 so the next doubling carries into the next digit.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        logic [3:0] result;
        if (digit >= BCD_ADJ_THRESHOLD) begin
            result = digit + BCD_ADJ_ADD;
        end else begin
            result = digit;
        end
        return result;
    endfunction

endpackage

// File: rtl/bin_to_bcd_dabble_digit_adjust.sv
// Combinational add-3-if->=5 correction for one BCD digit, applied between
// double-dabble shift steps.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Single-digit correction, purely combinational.
    always_comb begin
        adjusted = 4'd0;
        adjusted = bcd_adjust(digit);
    end

endmodule

// File: rtl/bin_to_bcd_dabble.sv
// Sequential double-dabble converter: latches a binary value on start, then
// alternates shift and add-3 steps and presents the packed BCD result with o_dv.
module bin_to_bcd_dabble
    import bcd_pkg::*;
#(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INPUT_WIDTH-1:0]              i_binary,
    input  logic                                i_start,
    output logic [BCD_DIGIT_W*DECIMAL_DIGITS-1:0] o_bcd,
    output logic                                o_dv,
    output logic                                o_busy,
    output logic                                o_overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DECIMAL_DIGITS;
    localparam int IDX_W = (INPUT_WIDTH > 2) ? $clog2(INPUT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_WIDTH - 1);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [INPUT_WIDTH-1:0]  shift_r;
    logic [BCD_W-1:0]        scratch_r;
    logic [BCD_W-1:0]        scratch_adj_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    sticky_r;

    // One adjust cell per digit; all digits are corrected in the same ADD cycle.
    for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (scratch_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: shift/add alternate until the last input bit has been shifted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            ADD:     state_next_s = SHIFT;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Conversion datapath: input shift register, BCD scratch, bit index, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= '0;
            scratch_r <= '0;
            idx_r     <= '0;
            sticky_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        shift_r   <= i_binary;
                        scratch_r <= '0;
                        idx_r     <= '0;
                        sticky_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A one leaving the top digit means the value needs more digits.
                    {scratch_r, shift_r} <= {scratch_r[BCD_W-2:0], shift_r, 1'b0};
                    idx_r                <= idx_r + IDX_W'(1);
                    if (scratch_r[BCD_W-1]) begin
                        sticky_r <= 1'b1;
                    end
                end
                ADD: begin
                    scratch_r <= scratch_adj_s;
                end
                default: begin
                    scratch_r <= scratch_r;
                end
            endcase
        end
    end

    // Registered outputs; the result is published only from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bcd      <= '0;
            o_dv       <= 1'b0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_dv   <= (state_r == DONE);
            o_busy <= (state_next_s != IDLE);
            if (state_r == DONE) begin
                o_bcd      <= scratch_r;
                o_overflow <= sticky_r;
            end
        end
    end

endmodule
